sramlike_mem_responder: RTL and testbench

- Slave/responder end of the sram-like CPU memory interface.
- Accepts split-transaction requests using the req/addr_ok handshake, buffers them in order, and returns completions on data_ok after a programmable latency.
- Backed by an internal byte-writable word memory.
- Used as the data/inst memory model behind the core's sram-like port and as the response side for bridge verification.

---
 rtl/sramlike_pkg.sv | 44 ++++
 rtl/sramlike_byte_ram.sv | 22 ++
 rtl/sramlike_mem_responder.sv | 124 ++++++++++++
 tb/tb_sramlike_mem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sramlike_pkg.sv
// Shared types for the sram-like memory responder: access sizes, queue entry
// layout and the byte-lane decoder.
package sramlike_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef struct packed {
    logic        wr;
    logic [3:0]  be;
    logic [29:0] idx;
    logic [31:0] wdata;
  } req_entry_t;

  typedef struct packed {
    logic [3:0] be;
    logic       misalign;
  } lane_t;

  // Misaligned or reserved accesses get an empty lane mask so they never write.
  function automatic lane_t lane_decode(input size_e sz, input logic [1:0] lo);
    lane_t r;
    r.be       = '0;
    r.misalign = 1'b0;
    case (sz)
      SZ_BYTE: r.be = 4'b0001 << lo;
      SZ_HALF: begin
        if (lo[0]) r.misalign = 1'b1;
        else       r.be = lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        if (lo != 2'b00) r.misalign = 1'b1;
        else             r.be = '1;
      end
      default: r.misalign = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sramlike_byte_ram.sv
// Word memory with per-byte write enables and asynchronous read; not reset.
module sramlike_byte_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/sramlike_mem_responder.sv
// Responder end of the sram-like interface: in-order request queue with
// per-entry age counters, retiring one matured head entry per cycle.
module sramlike_mem_responder
  import sramlike_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        accept_en,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        misalign_err
);

  localparam int         PW         = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int         CW         = $clog2(QDEPTH + 1);
  localparam logic [3:0] MATURE_AGE = 4'(LATENCY - 1);
  localparam logic [3:0] AGE_MAX    = 4'hF;

  req_entry_t        q   [QDEPTH];
  logic [3:0]        age [QDEPTH];
  logic [QDEPTH-1:0] occ;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  req_entry_t  head_e;
  req_entry_t  new_e;
  lane_t       lane;
  logic        accept;
  logic        retire;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic        unused_idx;

  assign lane = lane_decode(size_e'(size), addr[1:0]);

  always_comb begin
    new_e.wr    = wr;
    new_e.be    = lane.be;
    new_e.idx   = addr[31:2];
    new_e.wdata = wdata;
  end

  // count includes an entry retiring this cycle, so a full queue stays full.
  assign addr_ok = !rst && accept_en && (count < CW'(QDEPTH));
  assign accept  = req && addr_ok;

  assign head_e     = q[head];
  assign retire     = occ[head] && (age[head] >= MATURE_AGE);
  assign ram_be     = (retire && head_e.wr) ? head_e.be : 4'b0000;
  assign unused_idx = ^head_e.idx[29:ADDR_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) tail <= tail + 1'b1;
      if (retire) head <= head + 1'b1;
      case ({accept, retire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) age[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (accept && tail == PW'(i)) begin
          occ[i] <= 1'b1;
          age[i] <= '0;
        end else if (retire && head == PW'(i)) begin
          occ[i] <= 1'b0;
          age[i] <= '0;
        end else if (occ[i] && age[i] != AGE_MAX) begin
          age[i] <= age[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) q[tail] <= new_e;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_ok      <= 1'b0;
      rdata        <= '0;
      misalign_err <= 1'b0;
    end else begin
      data_ok <= retire;
      if (retire && !head_e.wr)     rdata        <= ram_rdata;
      if (accept && lane.misalign) misalign_err <= 1'b1;
    end
  end

  sramlike_byte_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .addr  (head_e.idx[ADDR_W-1:0]),
    .be    (ram_be),
    .wdata (head_e.wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Directed plus randomized bench; expectations come from a byte-array memory
// model and a completion-time rule: done = max(accept + LATENCY, prev_done + 1).
module tb_sramlike_mem_responder;

  localparam int AW = 12;
  localparam int L  = 2;
  localparam int Q  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        accept_en;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  typedef struct {
    int          comp;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        pend [$];
  logic [31:0] mm [int];
  logic [31:0] last_rdata;
  bit          exp_mis;
  int          last_comp;

  sramlike_mem_responder #(
    .ADDR_W  (AW),
    .LATENCY (L),
    .QDEPTH  (Q)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .wr           (wr),
    .size         (size),
    .addr         (addr),
    .wdata        (wdata),
    .accept_en    (accept_en),
    .addr_ok      (addr_ok),
    .data_ok      (data_ok),
    .rdata        (rdata),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] d, input bit ae,
                      output bit acc);
    bit         ok;
    bit         mis;
    bit         dok;
    int         e;
    int         n;
    int         idx;
    logic [3:0] be;
    exp_t       it;
    req = r; wr = w; size = sz; addr = a; wdata = d; accept_en = ae;
    @(negedge clk);
    ok = ae && (pend.size() < Q);
    check("addr_ok", {31'b0, addr_ok}, {31'b0, ok});
    acc = r && ok;
    @(posedge clk);
    #1;
    e = edge_n;
    if (acc) begin
      n   = 1 << sz;
      mis = (sz == 2'd3) || ((int'(a[1:0]) % n) != 0);
      be  = mis ? 4'b0000 : 4'(((1 << n) - 1) << a[1:0]);
      idx = int'((a >> 2) % (1 << AW));
      if (mis) exp_mis = 1'b1;
      it.comp   = (e + L > last_comp + 1) ? e + L : last_comp + 1;
      last_comp = it.comp;
      it.rd     = !w;
      it.data   = '0;
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) mm[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        it.data = mm[idx];
      end
      pend.push_back(it);
    end
    dok = 1'b0;
    if (pend.size() > 0 && pend[0].comp == e) begin
      dok = 1'b1;
      if (pend[0].rd) last_rdata = pend[0].data;
      void'(pend.pop_front());
    end
    check("data_ok", {31'b0, data_ok}, {31'b0, dok});
    check("rdata", rdata, last_rdata);
    check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
  endtask

  task automatic issue(input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d);
    bit acc = 1'b0;
    for (int k = 0; k < 50 && !acc; k++) step(1'b1, w, sz, a, d, 1'b1, acc);
    check("issue_accepted", {31'b0, acc}, 32'd1);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 100 && pend.size() > 0; k++) step(1'b0, 1'b0, 2'd0, '0, '0, 1'b1, acc);
    check("drain_empty", pend.size(), 32'd0);
    step(1'b0, 1'b0, 2'd0, '0, '0, 1'b1, acc);
  endtask

  task automatic reset_model();
    pend.delete();
    last_rdata = '0;
    exp_mis    = 1'b0;
    last_comp  = 0;
  endtask

  initial begin
    bit acc;
    int te;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = '0; addr = '0; wdata = '0; accept_en = 1'b1;
    reset_model();
    #1;
    check("rst_addr_ok", {31'b0, addr_ok}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_ok", {31'b0, data_ok}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 64; i++) issue(1'b1, 2'd2, 32'(i * 4), $urandom);
    drain();

    issue(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
    te = edge_n;
    step(1'b0, 1'b0, 2'd0, '0, '0, 1'b1, acc);
    step(1'b0, 1'b0, 2'd0, '0, '0, 1'b1, acc);
    check("wr_latency", {31'b0, data_ok}, 32'd1);
    check("wr_latency_edge", edge_n - te, 32'(L));
    issue(1'b0, 2'd2, 32'h100, '0);
    check("rd_accept_t3", edge_n - te, 32'd3);
    drain();
    check("rd_deadbeef", rdata, 32'hDEADBEEF);

    issue(1'b1, 2'd2, 32'h100, 32'h11223344);
    issue(1'b1, 2'd0, 32'h101, 32'h0000AA00);
    issue(1'b0, 2'd2, 32'h100, '0);
    drain();
    check("lane_byte", rdata, 32'h1122AA44);
    issue(1'b1, 2'd1, 32'h102, 32'h55660000);
    issue(1'b0, 2'd2, 32'h100, '0);
    drain();
    check("lane_half", rdata, 32'h5566AA44);

    for (int i = 0; i < 4; i++) issue(1'b0, 2'd2, 32'(i * 4), '0);
    drain();
    check("qdepth_last", rdata, mm[3]);

    issue(1'b1, 2'd2, 32'h200, 32'h0);
    issue(1'b0, 2'd2, 32'h200, '0);
    drain();
    check("raw_in_order", rdata, 32'h0);

    check("misalign_before", {31'b0, misalign_err}, 32'd0);
    issue(1'b1, 2'd1, 32'h203, 32'hFFFFFFFF);
    issue(1'b0, 2'd2, 32'h200, '0);
    drain();
    check("misalign_mem", rdata, 32'h0);
    check("misalign_set", {31'b0, misalign_err}, 32'd1);

    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           2'($urandom_range(0, 3)),
           32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3)),
           $urandom, $urandom_range(0, 3) != 0, acc);
    end
    drain();

    issue(1'b0, 2'd2, 32'h100, '0);
    issue(1'b0, 2'd2, 32'h200, '0);
    rst = 1'b1;
    req = 1'b0;
    #1;
    check("midrst_addr_ok", {31'b0, addr_ok}, 32'd0);
    reset_model();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("midrst_data_ok", {31'b0, data_ok}, 32'd0);
      check("midrst_addr_ok_hold", {31'b0, addr_ok}, 32'd0);
    end
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_misalign", {31'b0, misalign_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_data_ok", {31'b0, data_ok}, 32'd0);
    issue(1'b0, 2'd2, 32'h100, '0);
    drain();
    check("post_rst_persist", rdata, 32'h5566AA44);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
